// File: rtl/tx_ts_queue_pkg.sv
// ==========================================================================
// tx_ts_queue_pkg: shared sizes, capture FSM encoding, qualification helper. rev 1.0
// ==========================================================================
`timescale 1ns/1ps
`default_nettype none

package tx_ts_queue_pkg;

  localparam int TSQ_DEPTH = 4;
  localparam int TSQ_EW    = 100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_COMMIT = 2'd2
  } tsq_state_e;

  // Only two-step event messages (types 0..3) are queued; a one-step Sync or
  // Pdelay_Resp already carries its timestamp in the frame.
  function automatic logic frame_qualifies(
    input logic       queue_en,
    input logic       is_ptp,
    input logic [3:0] msg_type,
    input logic       one_step
  );
    logic ts_in_frame;
    ts_in_frame = one_step && ((msg_type == 4'd0) || (msg_type == 4'd3));
    return queue_en && is_ptp && (msg_type <= 4'd3) && !ts_in_frame;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tx_ts_queue_sync_fifo.sv
// ==========================================================================
// tsq_sync_fifo: timestamp entry storage with level, sticky overflow, 1-cycle read. rev 1.0
// ==========================================================================
`timescale 1ns/1ps
`default_nettype none

module tsq_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int EW    = 100
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en_i,
  input  logic                       push_i,
  input  logic [EW-1:0]              push_data_i,
  input  logic                       pop_i,
  input  logic                       clr_ovf_i,
  output logic                       rd_valid_o,
  output logic [EW-1:0]              rd_data_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       ovf_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          rd_valid_q, rd_valid_d;
  logic [EW-1:0] rd_data_q, rd_data_d;

  logic do_pop, do_push, full;

  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign full    = (level_q == LW'(DEPTH));
  assign do_pop  = pop_i && (level_q != '0);
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    ovf_d      = ovf_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    if (en_i) begin
      rd_valid_d = do_pop;
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_data_d = mem_q[rd_ptr_q];
        rd_ptr_d  = rd_ptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
        level_d = level_q + LW'(1);
      end else if (do_pop && !do_push) begin
        level_d = level_q - LW'(1);
      end
      // A fresh overflow outranks a coincident clear.
      if (push_i && full && !do_pop) begin
        ovf_d = 1'b1;
      end else if (clr_ovf_i) begin
        ovf_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
  assign level_o    = level_q;
  assign ovf_o      = ovf_q;

endmodule

`default_nettype wire

// File: rtl/tx_ts_queue.sv
// ==========================================================================
// tx_ts_queue: captures tx SFD timestamps of two-step PTP frames into a CPU-read queue. rev 1.0
// ==========================================================================
`timescale 1ns/1ps
`default_nettype none

module tx_ts_queue
  import tx_ts_queue_pkg::*;
#(
  parameter int DEPTH = TSQ_DEPTH,
  parameter int EW    = TSQ_EW
) (
  input  logic                   tx_clk,
  input  logic                   tx_rst_n,
  input  logic                   tx_clk_en_i,
  input  logic                   sfd_valid_i,
  input  logic [79:0]            sfd_timestamp_i,
  input  logic                   frame_end_i,
  input  logic                   is_ptp_message_i,
  input  logic [3:0]             ptp_messageType_i,
  input  logic [15:0]            ptp_seqId_i,
  input  logic                   one_step_flag_i,
  input  logic                   queue_en_i,
  input  logic                   rd_req_i,
  output logic                   rd_valid_o,
  output logic [EW-1:0]          rd_data_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   ovf_o,
  input  logic                   clr_ovf_i
);

  tsq_state_e  state_q, state_d;
  logic [79:0] ts_q, ts_d;
  logic [3:0]  type_q, type_d;
  logic [15:0] seq_q, seq_d;
  logic        push;
  logic [EW-1:0] entry;

  assign entry = {type_q, seq_q, ts_q};

  always_comb begin
    state_d = state_q;
    ts_d    = ts_q;
    type_d  = type_q;
    seq_d   = seq_q;
    push    = 1'b0;
    if (tx_clk_en_i) begin
      case (state_q)
        ST_IDLE: begin
          if (sfd_valid_i) begin
            ts_d    = sfd_timestamp_i;
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          // Parser results may change after frame end, so they are held here.
          if (frame_end_i) begin
            if (frame_qualifies(queue_en_i, is_ptp_message_i,
                                ptp_messageType_i, one_step_flag_i)) begin
              type_d  = ptp_messageType_i;
              seq_d   = ptp_seqId_i;
              state_d = ST_COMMIT;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (sfd_valid_i) begin
            ts_d = sfd_timestamp_i;
          end
        end
        ST_COMMIT: begin
          push = 1'b1;
          if (sfd_valid_i) begin
            ts_d    = sfd_timestamp_i;
            state_d = ST_HOLD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      state_q <= ST_IDLE;
      ts_q    <= '0;
      type_q  <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_d;
      type_q  <= type_d;
      seq_q   <= seq_d;
    end
  end

  tsq_sync_fifo #(
    .DEPTH (DEPTH),
    .EW    (EW)
  ) u_fifo (
    .clk         (tx_clk),
    .rst_n       (tx_rst_n),
    .en_i        (tx_clk_en_i),
    .push_i      (push),
    .push_data_i (entry),
    .pop_i       (rd_req_i),
    .clr_ovf_i   (clr_ovf_i),
    .rd_valid_o  (rd_valid_o),
    .rd_data_o   (rd_data_o),
    .level_o     (level_o),
    .ovf_o       (ovf_o)
  );

endmodule

`default_nettype wire
